// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: deserializes UART-style frames from a single pin
// and performs single-error correction on each 7-bit codeword.
//
// Ports:
//   io_in[0]  clk        rising-edge clock
//   io_in[1]  rst_n      asynchronous active-low reset
//   io_in[2]  rx         serial line, idles high, asynchronous to clk
//   io_in[7:3]           ignored
//   io_out[3:0] data     last correctly framed, decoded nibble
//   io_out[4]   valid    one-cycle strobe when data/corrected update
//   io_out[5]   corrected last good frame needed a single-bit fix
//   io_out[6]   frame_err last frame's stop bit sampled low
//   io_out[7]   busy     a frame is being received
module hamming74_serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    logic clk;
    logic rst_n;
    logic rx;
    logic unused_io;

    assign clk       = io_in[0];
    assign rst_n     = io_in[1];
    assign rx        = io_in[2];
    assign unused_io = ^io_in[7:3];

    logic             sync1_q;
    logic             rx_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [3:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             corrected_q, corrected_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic             half_done_c;
    logic             bit_done_c;
    logic [2:0]       syndrome_c;
    logic [6:0]       flip_c;
    logic [6:0]       fixed_c;
    logic [3:0]       nibble_c;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit timing counter, bit index and code shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            corrected_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            corrected_q <= corrected_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign half_done_c = (cnt_q == CNT_HALF_LAST);
    assign bit_done_c  = (cnt_q == CNT_BIT_LAST);

    // Syndrome decode of the fully shifted codeword; shift_q[i] is position i+1.
    always_comb begin
        syndrome_c = {shift_q[3] ^ shift_q[4] ^ shift_q[5] ^ shift_q[6],
                      shift_q[1] ^ shift_q[2] ^ shift_q[5] ^ shift_q[6],
                      shift_q[0] ^ shift_q[2] ^ shift_q[4] ^ shift_q[6]};
        flip_c = '0;
        if (syndrome_c != 3'd0) begin
            flip_c = 7'(1) << (syndrome_c - 3'd1);
        end
        fixed_c  = shift_q ^ flip_c;
        nibble_c = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (half_done_c) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    // LSB first: after seven shifts shift_q[0] holds c[0].
                    shift_d = {rx_s_q, shift_q[6:1]};
                    if (bit_cnt_q == 3'd6) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values; results only move at the stop-bit sample.
    always_comb begin
        data_d      = data_q;
        corrected_d = corrected_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;
        busy_d      = (state_d != S_IDLE);
        if ((state_q == S_STOP) && bit_done_c) begin
            if (rx_s_q) begin
                data_d      = nibble_c;
                corrected_d = (syndrome_c != 3'd0);
                frame_err_d = 1'b0;
                valid_d     = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign io_out = {busy_q, frame_err_q, corrected_q, valid_q, data_q};

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Self-checking bench for hamming74_serial_rx: a timing-schedule model derived from
// the frame-timing rules plus a nearest-codeword Hamming decoder predicts io_out on
// every cycle; directed frames add literal expectations.
module tb_hamming74_serial_rx;

    localparam int N    = 4;
    localparam int FS_W = (N / 4 < 1) ? 1 : N / 4;
    localparam int MAXC = 32768;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [4:0] junk = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {junk, rx, rst_n, clk};

    hamming74_serial_rx #(.CLKS_PER_BIT(N)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected-behaviour schedule indexed by cycle number.
    bit       busy_exp [MAXC];
    bit [1:0] ev_kind  [MAXC];   // 1 = good frame completes, 2 = frame error
    bit [3:0] ev_data  [MAXC];
    bit       ev_corr  [MAXC];

    logic [3:0] exp_data  = 4'h0;
    logic       exp_corr  = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_valid = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%02h expected=%02h", name, cyc, act, exp);
        end
    endtask

    // Hamming(7,4) encoder: positions 1..7, parity p at position p covers every
    // position whose index has bit p set.
    function automatic logic [6:0] hm_encode(input logic [3:0] nib);
        logic [7:1] pos;
        pos    = '0;
        pos[3] = nib[0];
        pos[5] = nib[1];
        pos[6] = nib[2];
        pos[7] = nib[3];
        for (int p = 1; p <= 4; p = p * 2)
            for (int i = 1; i <= 7; i++)
                if (((i & p) != 0) && (i != p)) pos[p] = pos[p] ^ pos[i];
        return pos;
    endfunction

    // Nearest-codeword decode; the code is perfect, so exactly one nibble is within distance 1.
    task automatic hm_decode(input logic [6:0] cw, output logic [3:0] nib, output logic corr);
        nib  = '0;
        corr = 1'b0;
        for (int n = 0; n < 16; n++) begin
            int d;
            d = $countones(hm_encode(4'(n)) ^ cw);
            if (d <= 1) begin
                nib  = 4'(n);
                corr = (d == 1);
            end
        end
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < MAXC) busy_exp[i] = 1'b1;
    endtask

    task automatic put_ev(input int at, input bit [1:0] kind, input bit [3:0] d, input bit c);
        if (at < MAXC) begin
            ev_kind[at] = kind;
            ev_data[at] = d;
            ev_corr[at] = c;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare process: every cycle io_out must match the schedule.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_data = 4'h0;
            exp_corr = 1'b0;
            exp_ferr = 1'b0;
            check("reset_io_out", io_out, 8'h00);
        end else if (cyc < MAXC) begin
            exp_valid = 1'b0;
            if (ev_kind[cyc] == 2'd1) begin
                exp_data  = ev_data[cyc];
                exp_corr  = ev_corr[cyc];
                exp_ferr  = 1'b0;
                exp_valid = 1'b1;
            end else if (ev_kind[cyc] == 2'd2) begin
                exp_ferr = 1'b1;
            end
            check("io_out", io_out, {busy_exp[cyc], exp_ferr, exp_corr, exp_valid, exp_data});
        end
    end

    // Frame starting now (cycle e at the pin); rx_s sees it 2 cycles later.
    task automatic send_frame(input logic [6:0] cw, input bit stop_ok,
                              input int hold_bits, input int gap_bits);
        int e;
        int ev;
        int r;
        logic [3:0] nib;
        logic corr;
        e  = cyc;
        ev = e + 3 + N / 2 + 8 * N;
        hm_decode(cw, nib, corr);
        if (stop_ok) begin
            set_busy(e + 3, ev - 1);
            put_ev(ev, 2'd1, nib, corr);
        end else begin
            r = e + 9 * N + hold_bits * N;
            set_busy(e + 3, r + 2);
            put_ev(ev, 2'd2, 4'h0, 1'b0);
        end
        junk = 5'($urandom);
        rx   = 1'b0;
        wait_cyc(N);
        for (int k = 0; k < 7; k++) begin
            rx = cw[k];
            wait_cyc(N);
        end
        rx = stop_ok;
        wait_cyc(N);
        if (!stop_ok) wait_cyc(hold_bits * N);
        rx = 1'b1;
        wait_cyc(gap_bits * N);
    endtask

    task automatic false_start();
        int e;
        e = cyc;
        set_busy(e + 3, e + 2 + N / 2);
        rx = 1'b0;
        wait_cyc(FS_W);
        rx = 1'b1;
        wait_cyc(2 * N);
    endtask

    // Literal expectations on the held outputs, sampled away from the edge.
    task automatic lit_check(input string name, input logic [3:0] d, input bit c, input bit f);
        @(negedge clk);
        check({name, "_data"}, {4'h0, io_out[3:0]}, {4'h0, d});
        check({name, "_corr"}, {7'h0, io_out[5]}, {7'h0, c});
        check({name, "_ferr"}, {7'h0, io_out[6]}, {7'h0, f});
        check({name, "_idle"}, {6'h0, io_out[7], io_out[4]}, 8'h00);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_frame();
        int e;
        e = cyc;
        set_busy(e + 3, e + 300);
        rx = 1'b0;
        wait_cyc(N);
        rx = 1'b1;
        wait_cyc(N);
        rx = 1'b0;
        wait_cyc(N);
        rx = 1'b1;
        wait_cyc(2);
        rst_n = 1'b0;
        for (int i = cyc; i < cyc + 400 && i < MAXC; i++) begin
            busy_exp[i] = 1'b0;
            ev_kind[i]  = 2'd0;
        end
        rx = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_io", io_out, 8'h00);
        @(posedge clk);
        #1;
        wait_cyc(N);
    endtask

    initial begin
        logic [3:0] pn;
        logic       pc;
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);

        // Pin the model with hand-computed values.
        check("pin_enc_B", {1'b0, hm_encode(4'hB)}, 8'h55);
        hm_decode(7'h51, pn, pc);
        check("pin_dec_51", {3'h0, pc, pn}, 8'h1B);
        hm_decode(7'h56, pn, pc);
        check("pin_dec_56", {3'h0, pc, pn}, 8'h1A);

        // Clean decode.
        send_frame(7'h00, 1'b1, 0, 2);
        lit_check("clean00", 4'h0, 1'b0, 1'b0);
        send_frame(7'h55, 1'b1, 0, 2);
        lit_check("clean55", 4'hB, 1'b0, 1'b0);

        // Single-bit correction in every position.
        for (int k = 0; k < 7; k++) begin
            send_frame(7'h55 ^ (7'(1) << k), 1'b1, 0, 1);
            lit_check("corr", 4'hB, 1'b1, 1'b0);
        end

        // False start then a real frame.
        send_frame(7'h00, 1'b1, 0, 2);
        false_start();
        lit_check("fstart_hold", 4'h0, 1'b0, 1'b0);
        send_frame(7'h55, 1'b1, 0, 2);
        lit_check("after_fstart", 4'hB, 1'b0, 1'b0);

        // Framing error with a long break, then recovery.
        send_frame(7'h00, 1'b1, 0, 2);
        send_frame(7'h55, 1'b0, 20, 2);
        lit_check("break", 4'h0, 1'b0, 1'b1);
        send_frame(7'h00, 1'b1, 0, 2);
        lit_check("after_break", 4'h0, 1'b0, 1'b0);

        // Back-to-back frames.
        send_frame(7'h55, 1'b1, 0, 0);
        send_frame(7'h51, 1'b1, 0, 0);
        send_frame(7'h00, 1'b1, 0, 2);
        lit_check("b2b", 4'h0, 1'b0, 1'b0);

        // Reset in the middle of DATA, then a clean frame.
        send_frame(7'h51, 1'b1, 0, 1);
        reset_mid_frame();
        send_frame(7'h55, 1'b1, 0, 2);
        lit_check("post_reset", 4'hB, 1'b0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            int sel;
            int emode;
            int a;
            int b;
            logic [3:0] nib;
            logic [6:0] cw;
            sel = $urandom_range(0, 99);
            if (sel < 6) begin
                false_start();
            end else begin
                nib   = 4'($urandom);
                cw    = hm_encode(nib);
                emode = $urandom_range(0, 99);
                if (emode < 35) begin
                    cw = cw ^ (7'(1) << $urandom_range(0, 6));
                end else if (emode < 42) begin
                    a  = $urandom_range(0, 6);
                    b  = (a + $urandom_range(1, 6)) % 7;
                    cw = cw ^ (7'(1) << a) ^ (7'(1) << b);
                end
                if (sel < 10)
                    send_frame(cw, 1'b0, $urandom_range(0, 4), $urandom_range(1, 2));
                else
                    send_frame(cw, 1'b1, 0, $urandom_range(0, 2));
            end
        end

        wait_cyc(4 * N);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming74_serial_rx.md
# hamming74_serial_rx

Serial receiver stage for the Hamming(7,4) link. It deserializes a UART-style bitstream of 7-bit Hamming codewords from a single input pin and performs single-error correction on each one. It presents the recovered nibble with valid, corrected and frame-error flags on the tile outputs. It sits downstream of the nibble encoder on the far side of a one-wire link and replaces the combinational decoder path when codewords arrive serially instead of in parallel.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit.
  - Must be even and ≥ 4.
  - Counter width is `$clog2(CLKS_PER_BIT)`.
- `io_in[0]` (clk), input, 1: the single clock; all state is on its rising edge.
- `io_in[1]` (rst_n), input, 1: reset, asynchronous and active-low.
- `io_in[2]` (rx), input, 1: serial line.
  - Idles high; asynchronous to clk.
- `io_in[7:3]`, input, 5: unused and ignored.
- `io_out[3:0]` (data), output, 4: last correctly framed, decoded nibble.
- `io_out[4]` (valid), output, 1: one-cycle strobe when data and corrected update.
- `io_out[5]` (corrected), output, 1: the last good frame had a nonzero syndrome and one bit was flipped.
- `io_out[6]` (frame_err), output, 1: the last frame's stop bit sampled low.
- `io_out[7]` (busy), output, 1: a frame is being received.

## Operation
- **Frame format:** start bit 0, then code bits c[0]..c[6] LSB first, then stop bit 1.
- **Codeword layout:** c[i] is Hamming position i+1.
  - Positions 1..7 are p1 p2 d1 p3 d2 d3 d4.
  - nibble[0] = d1 and nibble[3] = d4.
- **Syndrome:**
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
  - If s = {s3,s2,s1} ≠ 0, flip position s before extracting the data bits.
  - Double errors are miscorrected silently; no detection is required.
- **Synchronizer:** rx passes through a 2-flop synchronizer, giving rx_s. Both flops reset to 1.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s = 0, go to START and clear the counter.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - If 1, it is a false start; return to IDLE with no output change.
    - If 0, go to DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles into a shift register. After 7 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: load data and corrected, clear frame_err, pulse valid, go to IDLE.
    - If 0: set frame_err, leave data and corrected unchanged, do not pulse valid, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a stuck-low line from retriggering.
- **busy** is 1 in START, DATA, STOP and BREAK, and 0 in IDLE.
- **Output hold:** data, corrected and frame_err hold until the next completed frame.
- **Reset:**
  - All outputs are 0, and the state is IDLE.
  - Reset mid-frame aborts the frame; no partial result is ever output.

## Timing
- Let cycle 0 be the first cycle rx_s = 0 while in IDLE. Let N = CLKS_PER_BIT.
- The start sample is at cycle N/2.
- Code bit k (0..6) is sampled at cycle N/2 + (k+1)·N.
- The stop sample is at cycle N/2 + 8N.
- valid is high for exactly one cycle at N/2 + 8N + 1. data, corrected and frame_err change on that same cycle.
- busy:
  - Rises at cycle 1.
  - Falls at cycle N/2 + 8N + 1 on a good frame.
  - On a frame error, falls 1 cycle after rx_s returns high.
- Back-to-back frames: a new start bit may begin on the cycle immediately after the stop bit ends. IDLE accepts it, giving no dead time.
- Pin-to-rx_s latency is 2 cycles and is not counted in the figures above.

## Test plan
- **Reset:** assert rst_n = 0 mid-DATA, then release -> all io_out = 0x00. Then send a clean codeword 0x55 -> data = 0xB, corrected = 0, valid strobes once.
- **Clean decode (N = 4):** send codeword 0x00 -> data = 0x0. Then send 0x55 -> data = 0xB. Each valid pulse is exactly 1 cycle at cycle 35 after its start.
- **Single-bit correction:** send 0x51 (c[2] flipped in 0x55) -> data = 0xB, corrected = 1. Repeat for each of the 7 bit positions -> data = 0xB, corrected = 1 in every case.
- **False start:**
  - Pulse rx low for 1 bit-time/4 -> no valid, busy returns to 0, outputs unchanged.
  - Then send a real frame -> it decodes correctly.
- **Framing error and break:**
  - Send 0x55 with stop bit 0 and hold rx low for 20 bit-times -> frame_err = 1, data is still the previous value, no valid, busy stays 1 until rx rises.
  - Then send 0x00 -> frame_err = 0, data = 0x0.
- **Back-to-back:** send 0x55, 0x51 and 0x00 with no idle gap -> three valid pulses 9N cycles apart, reading data/corrected = B/0, B/1, 0/0.
